// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the base opcode encodings used by the decode stage.
package rv32i_pkg;

  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011
  } opcode_e;

endpackage

// File: rtl/id_stage_imm_gen.sv
// Combinational RV32I immediate generator: picks the I/S/B/U/J format from the
// opcode and sign-extends the result to XLEN. Register-register ops yield 0.
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int XLEN = rv32i_pkg::XLEN
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  // Assemble the 32-bit immediate according to the instruction format.
  always_comb begin
    imm32 = '0;
    case (instr[6:0])
      LOAD, OP_IMM, JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
      STORE:              imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      BRANCH:             imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                   instr[30:25], instr[11:8], 1'b0};
      LUI, AUIPC:         imm32 = {instr[31:12], 12'b0};
      JAL:                imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                   instr[20], instr[30:21], 1'b0};
      default:            imm32 = '0;
    endcase
  end

  // Widen to the datapath with sign extension.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// Decode stage: reads register operands, builds the execute bundle, and keeps a
// busy scoreboard of registers with writes in flight so RAW/WAW hazards stall.
//
// Handshake: both sides use valid/ready. A transfer happens on a rising edge
// where valid and ready are both 1. A producer holding valid=1 keeps its payload
// stable until the transfer; ready may depend combinationally on valid-side
// payload (hazard check) but valid never depends on ready.
module id_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN    = rv32i_pkg::XLEN,
  parameter int REG_NUM = rv32i_pkg::REG_NUM,
  parameter int SELW    = $clog2(REG_NUM) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [SELW-1:0] sel_read_reg1,
  output logic [SELW-1:0] sel_read_reg2,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] rf_rs2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            use_rs1;
  logic            use_rs2;
  logic            no_write;
  logic            dec_illegal;
  logic            dec_reg_write;
  logic [XLEN-1:0] dec_imm;
  logic [31:1]     busy;
  logic [31:0]     busy_full;
  logic [31:0]     busy_n;
  logic            hazard;
  logic            transfer;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];

  assign sel_read_reg1 = SELW'(rs1);
  assign sel_read_reg2 = SELW'(rs2);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr),
    .imm   (dec_imm)
  );

  // Classify the opcode: which sources it reads, whether it writes rd.
  always_comb begin
    use_rs1     = 1'b1;
    use_rs2     = 1'b0;
    no_write    = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      LUI, AUIPC, JAL:    use_rs1 = 1'b0;
      JALR, LOAD, OP_IMM: use_rs1 = 1'b1;
      BRANCH, STORE: begin
        use_rs2  = 1'b1;
        no_write = 1'b1;
      end
      OP:                 use_rs2 = 1'b1;
      default:            dec_illegal = 1'b1;
    endcase
  end

  assign dec_reg_write = !no_write && !dec_illegal && (rd != 5'd0);

  // x0 appears as a permanently idle entry so indexing by any register works.
  assign busy_full = {busy, 1'b0};

  // Registered busy bits only: a same-cycle writeback does not release a stall.
  assign hazard = (use_rs1 && busy_full[rs1]) ||
                  (use_rs2 && busy_full[rs2]) ||
                  (dec_reg_write && busy_full[rd]);

  assign if_ready = !reset && (!ex_valid || ex_ready) && !hazard && !flush;
  assign transfer = if_valid && if_ready;

  // Next scoreboard: writeback and flush clear, an accepted writer sets last.
  always_comb begin
    busy_n = busy_full;
    if (wb_valid && wb_rd != 5'd0)
      busy_n[wb_rd] = 1'b0;
    if (flush && ex_valid && ex_reg_write)
      busy_n[ex_rd] = 1'b0;
    if (transfer && dec_reg_write)
      busy_n[rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_n[31:1];
  end

  // Execute bundle register: load on transfer, drop on flush or consumption.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (transfer) begin
      ex_valid     <= 1'b1;
      ex_pc        <= if_pc;
      ex_rs1_val   <= rf_rs1;
      ex_rs2_val   <= rf_rs2;
      ex_imm       <= dec_imm;
      ex_rd        <= rd;
      ex_opcode    <= opcode;
      ex_funct3    <= if_instr[14:12];
      ex_funct7b5  <= if_instr[30];
      ex_reg_write <= dec_reg_write;
      ex_illegal   <= dec_illegal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule
